// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock through trial subtraction and reports
// the result with a one-cycle done pulse. A zero divisor skips the iterations
// and returns a saturated quotient with the dividend as the remainder.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  // The partial remainder is always below the divisor between iterations,
  // so its top bit is zero and only WIDTH bits need to be held.
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] r_iter_s;
  logic [WIDTH-1:0] q_iter_s;
  logic             last_s;

  // One restoring step: shift in the next dividend bit, try the subtraction,
  // keep the difference only when it did not borrow.
  always_comb begin
    r_shift_s = {r_r, q_r[WIDTH-1]};
    trial_s   = r_shift_s - {1'b0, d_r};
    if (trial_s[WIDTH] == 1'b0) begin
      r_iter_s = trial_s[WIDTH-1:0];
      q_iter_s = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      r_iter_s = r_shift_s[WIDTH-1:0];
      q_iter_s = {q_r[WIDTH-2:0], 1'b0};
    end
    last_s = (cnt_r == CNT_ONE);
  end

  // Control FSM, working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_r   <= {WIDTH{1'b0}};
            q_r   <= dividend;
            d_r   <= divisor;
            cnt_r <= CNT_INIT;
            if (divisor == {WIDTH{1'b0}}) begin
              // Divide-by-zero: report straight away, no iterations.
              state_r     <= DONE;
              done        <= 1'b1;
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_r <= RUN;
              busy    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          r_r   <= r_iter_s;
          q_r   <= q_iter_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (last_s) begin
            // Final step: publish the result from this step directly.
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_iter_s;
            remainder   <= r_iter_s;
            div_by_zero <= 1'b0;
          end else begin
            state_r <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=4).
// The driver pushes expected results computed with plain / and %; a monitor
// on the falling edge checks busy, done timing, results and result hold.
module tb_seq_restoring_divider;

  localparam int W = 4;
  localparam int MAXQ = (1 << W) - 1;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int issue;
    int done_cyc;
  } op_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int  checks;
  int  errors;
  int  cyc;
  op_t sb[$];
  op_t mon_op;
  int  exp_busy;
  int  exp_done;
  int  last_q;
  int  last_r;
  int  last_z;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares against the scoreboard head every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q = 0;
      last_r = 0;
      last_z = 0;
    end else begin
      exp_busy = 0;
      exp_done = 0;
      if (sb.size() > 0) begin
        exp_busy = (sb[0].dbz == 0 && cyc > sb[0].issue && cyc < sb[0].done_cyc) ? 1 : 0;
        exp_done = (cyc == sb[0].done_cyc) ? 1 : 0;
      end
      chk("busy", int'(busy), exp_busy);
      chk("done", int'(done), exp_done);
      if (done && sb.size() > 0) begin
        mon_op = sb.pop_front();
        chk("quotient", int'(quotient), mon_op.q);
        chk("remainder", int'(remainder), mon_op.r);
        chk("div_by_zero", int'(div_by_zero), mon_op.dbz);
        if (mon_op.dbz == 0) begin
          chk("invariant", int'(quotient) * mon_op.b + int'(remainder), mon_op.a);
          chk("rem_lt_div", (int'(remainder) < mon_op.b) ? 1 : 0, 1);
        end
        last_q = mon_op.q;
        last_r = mon_op.r;
        last_z = mon_op.dbz;
      end else if (!done) begin
        chk("hold_quotient", int'(quotient), last_q);
        chk("hold_remainder", int'(remainder), last_r);
        chk("hold_dbz", int'(div_by_zero), last_z);
      end
    end
  end

  // Issue one request; call at a falling edge, returns one cycle later.
  task automatic send(input int a, input int b);
    op_t op;
    op.a = a;
    op.b = b;
    op.dbz = (b == 0) ? 1 : 0;
    op.q = (b == 0) ? MAXQ : a / b;
    op.r = (b == 0) ? a : a % b;
    op.issue = cyc;
    op.done_cyc = cyc + ((b == 0) ? 1 : W + 1);
    sb.push_back(op);
    start = 1'b1;
    dividend = a[W-1:0];
    divisor = b[W-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the scoreboard to drain, scrambling operands meanwhile.
  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      dividend = W'($urandom);
      divisor = W'($urandom);
      n++;
    end
    if (sb.size() > 0) begin
      chk("timeout_idle", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Wait until the done cycle (bounded) so the next start lands in it.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("timeout_done", int'(done), 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic case and boundary operands.
    send(13, 3);
    wait_idle();
    send(15, 1);
    wait_idle();
    send(7, 9);
    wait_idle();
    send(0, 5);
    wait_idle();

    // Divide-by-zero followed by a normal division.
    send(9, 0);
    wait_idle();
    send(8, 2);
    wait_idle();

    // A start while busy must be ignored.
    send(14, 4);
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);

    // Reset in the middle of a division.
    send(12, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send(12, 5);
    wait_idle();

    // Back-to-back: second start in the first done cycle.
    send(10, 3);
    wait_done();
    send(6, 4);
    wait_idle();

    // Divide-by-zero chained directly into another request.
    send(5, 0);
    wait_done();
    send(11, 2);
    wait_idle();

    // Exhaustive sweep of every operand pair.
    for (int a = 0; a <= MAXQ; a++) begin
      for (int b = 0; b <= MAXQ; b++) begin
        send(a, b);
        wait_idle();
      end
    end

    // Randomized traffic with occasional back-to-back requests.
    for (int k = 0; k < 150; k++) begin
      int ra;
      int rb;
      ra = $urandom_range(0, MAXQ);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXQ);
      send(ra, rb);
      if ($urandom_range(0, 2) == 0) wait_done();
      else wait_idle();
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
